// File: rtl/instqueue_multi_pkg.sv
// Shared fetch/decode definitions: default widths and the fetch-entry record.
package instqueue_multi_pkg;

    localparam int IDWidth      = 32;
    localparam int AddressWidth = 32;

    // One fetched instruction as it travels from fetch to decode.
    typedef struct packed {
        logic [IDWidth-1:0]      inst;
        logic [AddressWidth-1:0] pc;
        logic                    pred;
    } fetch_entry_t;

endpackage

// File: rtl/instqueue_ram.sv
// Instruction queue storage: one synchronous write port, one asynchronous read port.
module instqueue_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 65
) (
    input  logic                     clk_in,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write the entry at the tail slot; contents are never cleared.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instqueue_multi.sv
// Instruction queue between fetch and decode: circular buffer with exact
// occupancy, almost-full backpressure, registered single issue, one-cycle flush.
module instqueue_multi
    import instqueue_multi_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SLACK = 2,
    parameter int IW    = IDWidth,
    parameter int AW    = AddressWidth
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       if_instqueue_en_in,
    input  logic [IW-1:0]              if_instqueue_inst_in,
    input  logic [AW-1:0]              if_instqueue_pc_in,
    input  logic                       if_instqueue_pred_in,
    output logic                       instqueue_if_full_out,
    input  logic                       rs_instqueue_rdy_in,
    input  logic                       rob_instqueue_rdy_in,
    input  logic                       rob_instqueue_rst_in,
    input  logic                       decoder_instqueue_rst_in,
    input  logic                       bp_instqueue_rst_in,
    output logic                       instqueue_decoder_en_out,
    output logic [IW-1:0]              instqueue_decoder_inst_out,
    output logic [AW-1:0]              instqueue_decoder_pc_out,
    output logic                       instqueue_decoder_pred_out,
    output logic [$clog2(DEPTH+1)-1:0] instqueue_count_out,
    output logic                       instqueue_overflow_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = IW + AW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          overflow;
    logic [EW-1:0] rd_entry;

    logic flush;
    logic is_full;
    logic is_empty;
    logic enq_ok;
    logic issue;
    logic write_en;

    // Occupancy comes only from count, never from pointer comparison.
    assign flush    = rob_instqueue_rst_in | decoder_instqueue_rst_in | bp_instqueue_rst_in;
    assign is_full  = (count == CW'(DEPTH));
    assign is_empty = (count == '0);
    assign enq_ok   = if_instqueue_en_in & ~is_full;
    assign issue    = rs_instqueue_rdy_in & rob_instqueue_rdy_in & ~is_empty;
    assign write_en = ~rst_in & rdy_in & ~flush & enq_ok;

    instqueue_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk_in (clk_in),
        .we     (write_en),
        .waddr  (tail),
        .wdata  ({if_instqueue_inst_in, if_instqueue_pc_in, if_instqueue_pred_in}),
        .raddr  (head),
        .rdata  (rd_entry)
    );

    // Pointer, occupancy, overflow and decoder-output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head                       <= '0;
            tail                       <= '0;
            count                      <= '0;
            overflow                   <= 1'b0;
            instqueue_decoder_en_out   <= 1'b0;
            instqueue_decoder_inst_out <= '0;
            instqueue_decoder_pc_out   <= '0;
            instqueue_decoder_pred_out <= 1'b0;
        end else if (rdy_in) begin
            if (flush) begin
                // Discards the incoming fetch entry and any in-flight issue.
                head                     <= '0;
                tail                     <= '0;
                count                    <= '0;
                instqueue_decoder_en_out <= 1'b0;
            end else begin
                if (if_instqueue_en_in && is_full) begin
                    overflow <= 1'b1;
                end
                if (enq_ok) begin
                    tail <= tail + PW'(1);
                end
                if (issue) begin
                    head                       <= head + PW'(1);
                    instqueue_decoder_en_out   <= 1'b1;
                    instqueue_decoder_inst_out <= rd_entry[EW-1 -: IW];
                    instqueue_decoder_pc_out   <= rd_entry[AW:1];
                    instqueue_decoder_pred_out <= rd_entry[0];
                end else begin
                    instqueue_decoder_en_out   <= 1'b0;
                end
                case ({enq_ok, issue})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign instqueue_if_full_out  = (count >= CW'(DEPTH - SLACK));
    assign instqueue_count_out    = count;
    assign instqueue_overflow_out = overflow;

endmodule

// File: tb/tb_instqueue_multi.sv
// Scoreboard bench for instqueue_multi (DEPTH=16, SLACK=2).
module tb_instqueue_multi;
    import instqueue_multi_pkg::*;

    localparam int DEPTH = 16;
    localparam int SLACK = 2;

    logic        clk = 1'b0;
    logic        rst, rdy, en, pred, rs, rob, rob_f, dec_f, bp_f;
    logic [31:0] inst, pc;
    logic        full_o, en_o, pred_o, ovf_o;
    logic [31:0] inst_o, pc_o;
    logic [4:0]  count_o;

    always #5 clk = ~clk;

    instqueue_multi #(.DEPTH(DEPTH), .SLACK(SLACK), .IW(32), .AW(32)) dut (
        .clk_in                     (clk),
        .rst_in                     (rst),
        .rdy_in                     (rdy),
        .if_instqueue_en_in         (en),
        .if_instqueue_inst_in       (inst),
        .if_instqueue_pc_in         (pc),
        .if_instqueue_pred_in       (pred),
        .instqueue_if_full_out      (full_o),
        .rs_instqueue_rdy_in        (rs),
        .rob_instqueue_rdy_in       (rob),
        .rob_instqueue_rst_in       (rob_f),
        .decoder_instqueue_rst_in   (dec_f),
        .bp_instqueue_rst_in        (bp_f),
        .instqueue_decoder_en_out   (en_o),
        .instqueue_decoder_inst_out (inst_o),
        .instqueue_decoder_pc_out   (pc_o),
        .instqueue_decoder_pred_out (pred_o),
        .instqueue_count_out        (count_o),
        .instqueue_overflow_out     (ovf_o)
    );

    // Reference model state
    fetch_entry_t sb[$];
    int           mcount;
    logic         exp_en, exp_ovf, exp_pred;
    logic [31:0]  exp_inst, exp_pc;
    int           vecs = 0;
    int           miss = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] p);
        return (p * 32'd7) ^ 32'h1357_9BDF;
    endfunction

    task automatic drive_fetch(input logic [31:0] p);
        en   = 1'b1;
        pc   = p;
        inst = inst_of(p);
        pred = p[2] ^ p[4];
    endtask

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic tick();
        fetch_entry_t e;
        bit acc, iss;
        if (rst) begin
            mcount = 0; sb.delete(); exp_en = 0; exp_ovf = 0;
            exp_inst = '0; exp_pc = '0; exp_pred = 0;
        end else if (rdy) begin
            if (rob_f || dec_f || bp_f) begin
                mcount = 0; sb.delete(); exp_en = 0;
            end else begin
                acc = en && (mcount < DEPTH);
                iss = rs && rob && (mcount > 0);
                if (en && mcount == DEPTH) exp_ovf = 1;
                if (iss) begin
                    e = sb.pop_front();
                    exp_en = 1; exp_inst = e.inst; exp_pc = e.pc; exp_pred = e.pred;
                end else begin
                    exp_en = 0;
                end
                if (acc) begin
                    e.inst = inst; e.pc = pc; e.pred = pred;
                    sb.push_back(e);
                end
                mcount = mcount + int'(acc) - int'(iss);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; rdy = 1; en = 0; inst = '0; pc = '0; pred = 0;
        rs = 0; rob = 0; rob_f = 0; dec_f = 0; bp_f = 0;
        tick(); tick();
        rst = 0;
        vecs++; if (en_o !== 1'b0) begin miss++; $display("FAIL reset_en: got %0b want 0", en_o); end
        vecs++; if (pc_o !== 32'h0) begin miss++; $display("FAIL reset_pc: got %0h want 0", pc_o); end
        vecs++; if (inst_o !== 32'h0) begin miss++; $display("FAIL reset_inst: got %0h want 0", inst_o); end
        vecs++; if (count_o !== 5'd0) begin miss++; $display("FAIL reset_count: got %0d want 0", count_o); end
        vecs++; if (full_o !== 1'b0) begin miss++; $display("FAIL reset_full: got %0b want 0", full_o); end
        vecs++; if (ovf_o !== 1'b0) begin miss++; $display("FAIL reset_ovf: got %0b want 0", ovf_o); end
    endtask

    task automatic test_back_to_back();
        int first_issue = -1;
        rs = 1; rob = 1;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 3) drive_fetch(32'(4 * (c - 1))); else en = 0;
            tick();
            if (en_o === 1'b1 && first_issue < 0) first_issue = c;
            vecs++; if (en_o !== exp_en) begin miss++; $display("FAIL b2b_en c%0d: got %0b want %0b", c, en_o, exp_en); end
            if (exp_en) begin
                vecs++; if (pc_o !== exp_pc || inst_o !== exp_inst || pred_o !== exp_pred) begin
                    miss++; $display("FAIL b2b_data c%0d: got pc %0h inst %0h want pc %0h inst %0h", c, pc_o, inst_o, exp_pc, exp_inst);
                end
            end
        end
        vecs++; if (first_issue != 2) begin miss++; $display("FAIL b2b_latency: got cycle %0d want 2", first_issue); end
        vecs++; if (count_o !== 5'd0) begin miss++; $display("FAIL b2b_count: got %0d want 0", count_o); end
    endtask

    task automatic test_fill_overflow();
        rs = 0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            drive_fetch(32'h100 + 32'(4 * i));
            tick();
            vecs++; if (count_o !== 5'(mcount)) begin miss++; $display("FAIL fill_count i%0d: got %0d want %0d", i, count_o, mcount); end
            vecs++; if (full_o !== (mcount >= DEPTH - SLACK)) begin miss++; $display("FAIL fill_full i%0d: got %0b at count %0d", i, full_o, mcount); end
        end
        en = 0;
        vecs++; if (count_o !== 5'd16) begin miss++; $display("FAIL fill_cap: got %0d want 16", count_o); end
        vecs++; if (ovf_o !== 1'b1) begin miss++; $display("FAIL fill_ovf: got %0b want 1", ovf_o); end
    endtask

    task automatic test_wrap_full();
        rs = 1; rob = 1;
        for (int i = 0; i < 20; i++) begin
            drive_fetch(32'h1000 + 32'(4 * i));
            tick();
            vecs++; if (en_o !== exp_en || pc_o !== exp_pc || inst_o !== exp_inst) begin
                miss++; $display("FAIL wrap_issue i%0d: got en %0b pc %0h want en %0b pc %0h", i, en_o, pc_o, exp_en, exp_pc);
            end
            vecs++; if (count_o !== 5'(mcount)) begin miss++; $display("FAIL wrap_count i%0d: got %0d want %0d", i, count_o, mcount); end
        end
        en = 0;
    endtask

    task automatic test_flush();
        for (int src = 0; src < 3; src++) begin
            rs = 0; rob = 1;
            for (int i = 0; i < 5; i++) begin drive_fetch(32'h2000 + 32'(src * 64 + 4 * i)); tick(); end
            if (src == 0) begin rs = 1; en = 0; tick(); rs = 0; end
            vecs++; if (count_o !== 5'(mcount)) begin miss++; $display("FAIL flush_pre%0d: got %0d want %0d", src, count_o, mcount); end
            rob_f = (src == 0); dec_f = (src == 1); bp_f = (src == 2);
            drive_fetch(32'hDEAD_0000); rs = 1;
            tick();
            rob_f = 0; dec_f = 0; bp_f = 0; en = 0;
            vecs++; if (count_o !== 5'd0) begin miss++; $display("FAIL flush_count%0d: got %0d want 0", src, count_o); end
            vecs++; if (en_o !== 1'b0) begin miss++; $display("FAIL flush_en%0d: got %0b want 0", src, en_o); end
            for (int k = 0; k < 3; k++) begin
                tick();
                vecs++; if (en_o !== 1'b0) begin miss++; $display("FAIL flush_stale%0d: got en %0b pc %0h want no issue", src, en_o, pc_o); end
            end
        end
        vecs++; if (ovf_o !== exp_ovf) begin miss++; $display("FAIL flush_ovf_kept: got %0b want %0b", ovf_o, exp_ovf); end
    endtask

    task automatic test_hold();
        logic [31:0] held_pc;
        logic [4:0]  held_cnt;
        rs = 1; rob = 1;
        for (int i = 0; i < 4; i++) begin drive_fetch(32'h3000 + 32'(4 * i)); tick(); end
        held_pc = pc_o; held_cnt = count_o;
        vecs++; if (en_o !== 1'b1) begin miss++; $display("FAIL hold_setup: got en %0b want 1", en_o); end
        rdy = 0; drive_fetch(32'h3F00);
        for (int k = 0; k < 3; k++) begin
            tick();
            vecs++; if (en_o !== 1'b1 || pc_o !== held_pc || count_o !== held_cnt) begin
                miss++; $display("FAIL hold_freeze k%0d: got en %0b pc %0h cnt %0d want en 1 pc %0h cnt %0d", k, en_o, pc_o, count_o, held_pc, held_cnt);
            end
        end
        rdy = 1; en = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            vecs++; if (en_o !== exp_en || pc_o !== exp_pc) begin
                miss++; $display("FAIL hold_drain k%0d: got en %0b pc %0h want en %0b pc %0h", k, en_o, pc_o, exp_en, exp_pc);
            end
        end
        vecs++; if (count_o !== 5'd0) begin miss++; $display("FAIL hold_empty: got %0d want 0", count_o); end
    endtask

    task automatic test_reset_midstream();
        rs = 0;
        for (int i = 0; i < 3; i++) begin drive_fetch(32'h4000 + 32'(4 * i)); tick(); end
        en = 0; rdy = 0; rst = 1;
        tick();
        rst = 0; rdy = 1;
        vecs++; if (en_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0 || pred_o !== 1'b0) begin
            miss++; $display("FAIL midrst_out: got en %0b pc %0h inst %0h pred %0b want all 0", en_o, pc_o, inst_o, pred_o);
        end
        vecs++; if (count_o !== 5'd0 || full_o !== 1'b0) begin miss++; $display("FAIL midrst_count: got cnt %0d full %0b want 0 0", count_o, full_o); end
        vecs++; if (ovf_o !== 1'b0) begin miss++; $display("FAIL midrst_ovf: got %0b want 0", ovf_o); end
        rs = 1;
        tick();
        vecs++; if (en_o !== 1'b0) begin miss++; $display("FAIL midrst_stale: got en %0b want 0", en_o); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fill_overflow();
        test_wrap_full();
        test_flush();
        test_hold();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
